btn_op_sequencer: RTL
=====================

# btn_op_sequencer

Front-end input stage of the ALU board design: synchronizes and debounces the four operation buttons and the centre button, and turns debounced presses into a registered 3-bit ALU operation code plus clean single-cycle event pulses. Sits directly upstream of the ALU, LED, anode and display drivers, which consume `op`. It also sits upstream of the BCD converter, which consumes `btnc_rise`/`btnc_db`. It replaces raw-level button-to-op mapping with press-driven stepping through operations.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive stable cycles required to accept a level change; minimum 2.
- `clk`  input  1  system clock (100 MHz on board).
- `reset_n`  input  1  asynchronous, active-low reset; one clock domain only.
- `btns`  input  4  raw, asynchronous, bouncing buttons: [0] up, [1] down, [2] clear, [3] lock toggle.
- `btnc`  input  1  raw, asynchronous centre button.
- `op`  output  3  registered current ALU operation code.
- `op_changed`  output  1  one-cycle pulse when `op` takes a new value.
- `locked`  output  1  registered; 1 = up/down/clear ignored.
- `btns_db`  output  4  debounced levels of `btns`.
- `btnc_db`  output  1  debounced level of `btnc`.
- `btnc_rise`  output  1  one-cycle pulse on each debounced rising edge of `btnc`.

## Operation
- Per input (5 total): two-flop synchronizer → debounce counter (width clog2(DEBOUNCE_CYCLES+1)) → debounced level register → rise detector.
- Counter rule: if synced input == debounced level, counter ← 0. Otherwise counter increments. When counter == DEBOUNCE_CYCLES−1 with mismatch still present, debounced level ← synced input and counter ← 0.
- Any mismatch run shorter than DEBOUNCE_CYCLES leaves the level unchanged (glitch rejection).
- Rise pulse per input is registered and asserted in the same cycle the debounced level goes 0→1. Falling edges produce no events.
- Op update, evaluated on the internal rise pulses r0..r3, takes effect next cycle:
  - clear (r2) and not locked: op ← 0 (highest priority).
  - else r0 and r1 together: no change.
  - else r0 and not locked: op ← op+1 mod 8 (7→0).
  - else r1 and not locked: op ← op−1 mod 8 (0→7).
  - r3: locked ← ~locked. The lock value before the toggle governs any other rise in the same cycle.
- `op_changed` asserts only if the new op differs from the old. Clear at op=0 gives no pulse.
- Reset values: `op`=0, `op_changed`=0, `locked`=0, all `btns_db`/`btnc_db`=0, `btnc_rise`=0, all synchronizer flops, counters and rise registers 0.
- Reset asserted mid-count discards partial counts. After release, a held button needs a full fresh window and produces a rise pulse if held.

## Timing
- Raw edge sampled at cycle 0 → synced at cycle 2 → debounced level and rise pulse at cycle 2+DEBOUNCE_CYCLES (±1 cycle synchronizer uncertainty for asynchronous edges).
- `op`, `locked` and `op_changed` update one cycle after the rise pulse.
- All rise pulses and `op_changed` are exactly one cycle wide. Holding a button never repeats an event.
- Every output is a flop output; no combinational path from inputs to outputs.
- Reset is asserted asynchronously and deassertion is synchronous to `clk` (via reset synchronizer upstream, or provided clean).

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset: hold `reset_n`=0, toggle all inputs → all outputs 0. Release with inputs low → outputs stay 0 for 20 cycles.
- Bounce: `btns[0]` toggles every 2 cycles for 12 cycles, then high for 10 → exactly one `op_changed`, op 0→1. A 3-cycle glitch afterward → no event.
- Wrap: 7 up presses from 0 → op=7; one more up → op=0 with `op_changed`; one down → op=7.
- Simultaneous: up+down rise in the same cycle at op=3 → op=3, no pulse. Clear+up rise at op=3 → op=0, `op_changed`=1.
- Lock: press `btns[3]` → `locked`=1; up, down and clear presses leave op=5 and produce no `op_changed`. Press `btns[3]` again → `locked`=0; up gives op=6.
- Centre and reset: `btnc` held 10 cycles → `btnc_db`=1 and one `btnc_rise` at cycle 6±1. Assert `reset_n` low at cycle 3 of a `btnc` window and release while held → `btnc_rise` is produced only a full window after release.

Source files
------------

// File: rtl/btn_op_sequencer.sv
// Purpose : synchronise and debounce the four op buttons and the centre button,
//           then step a registered 3-bit ALU op code on debounced presses.
// Latency : raw edge -> debounced level/rise pulse in 2+DEBOUNCE_CYCLES cycles
//           (+-1 for async edges); op/locked/op_changed follow one cycle later.
// Backpressure: none. Events are single-cycle pulses and are never queued.
//
// Ports:
//   i_clk, i_reset_n  : clock, asynchronous active-low reset
//   i_btns[3:0]       : raw buttons [0] up, [1] down, [2] clear, [3] lock toggle
//   i_btnc            : raw centre button
//   o_op              : current ALU operation code
//   o_op_changed      : one-cycle pulse when o_op takes a new value
//   o_locked          : 1 = up/down/clear ignored
//   o_btns_db         : debounced levels of i_btns
//   o_btnc_db         : debounced level of i_btnc
//   o_btnc_rise       : one-cycle pulse on each debounced rising edge of i_btnc
module btn_op_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [3:0] i_btns,
   input  logic       i_btnc,
   output logic [2:0] o_op,
   output logic       o_op_changed,
   output logic       o_locked,
   output logic [3:0] o_btns_db,
   output logic       o_btnc_db,
   output logic       o_btnc_rise
);

   localparam int NIN = 5;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Bit 4 is the centre button, bits 3:0 the op buttons.
   logic [NIN-1:0] w_raw;
   logic [NIN-1:0] r_sync1;
   logic [NIN-1:0] r_sync2;
   logic [NIN-1:0] r_db;
   logic [NIN-1:0] r_rise;
   logic [CW-1:0]  r_cnt [NIN];

   assign w_raw = {i_btnc, i_btns};

   // ------------------------------------------------------------------
   // Two-flop synchronisers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------
   // Debounce counters, debounced levels and rise registers.
   // The counter measures the length of the current mismatch run between
   // the synchronised input and the accepted level; any agreement restarts
   // it, so only an unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
   // The rise pulse is loaded on the same edge as the 0->1 level change.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_db   <= '0;
         r_rise <= '0;
         for (int i = 0; i < NIN; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NIN; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i]  <= '0;
               r_rise[i] <= 1'b0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_db[i]   <= r_sync2[i];
               r_cnt[i]  <= '0;
               r_rise[i] <= r_sync2[i];
            end else begin
               r_cnt[i]  <= r_cnt[i] + CNT_ONE;
               r_rise[i] <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Op / lock state: register, next-state logic, outputs
   // ------------------------------------------------------------------
   logic [2:0] r_op;
   logic       r_op_changed;
   logic       r_locked;
   logic [2:0] w_op_next;
   logic       w_locked_next;
   logic       w_up;
   logic       w_down;
   logic       w_clear;
   logic       w_lock_tgl;

   assign w_up       = r_rise[0];
   assign w_down     = r_rise[1];
   assign w_clear    = r_rise[2];
   assign w_lock_tgl = r_rise[3];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_op         <= 3'd0;
         r_op_changed <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_op         <= w_op_next;
         r_op_changed <= (w_op_next != r_op);
         r_locked     <= w_locked_next;
      end
   end

   // r_locked here is the value before any toggle in this cycle, so a lock
   // press coinciding with an up/down/clear press does not affect that press.
   always_comb begin
      w_op_next     = r_op;
      w_locked_next = r_locked;
      if (w_clear && !r_locked) begin
         w_op_next = 3'd0;
      end else if (w_up && w_down) begin
         w_op_next = r_op;
      end else if (w_up && !r_locked) begin
         w_op_next = r_op + 3'd1;
      end else if (w_down && !r_locked) begin
         w_op_next = r_op - 3'd1;
      end
      if (w_lock_tgl) begin
         w_locked_next = ~r_locked;
      end
   end

   // Every output is a flop output.
   always_comb begin
      o_op         = r_op;
      o_op_changed = r_op_changed;
      o_locked     = r_locked;
      o_btns_db    = r_db[3:0];
      o_btnc_db    = r_db[4];
      o_btnc_rise  = r_rise[4];
   end

endmodule
